// File: rtl/iq_avg_snapshot_ctrl_if.sv
// ---------------------------------------------------------------------------
// iq_avg_snapshot_ctrl_if
//   Groups the ss_ctrl control word, the averaged I/Q sample stream, the
//   capture BRAM write port and the status word used by the
//   iq_avg_snapshot_ctrl block. All signals live in the user_clk domain.
//
//   Signals:
//     ctrl_word  [31:0]        ss_ctrl register value
//                              ([0] arm, [1] sync_mode, [2] abort, [31:16] len)
//     din        [DATA_W-1:0]  averaged I/Q sample (I high half, Q low half)
//     din_valid                din qualifier
//     din_sync                 one-cycle frame-start pulse
//     bram_addr  [ADDR_W-1:0]  capture write address
//     bram_data  [DATA_W-1:0]  capture write data
//     bram_we                  capture write enable
//     status     [31:0]        {done, busy, waiting, 13'b0, count[15:0]}
//
//   Modports:
//     master  drives control and sample inputs, observes BRAM port and status
//     slave   the snapshot controller itself
// ---------------------------------------------------------------------------
interface iq_avg_snapshot_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
);
  logic [31:0]       ctrl_word;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_sync;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_data;
  logic              bram_we;
  logic [31:0]       status;

  modport master (
    output ctrl_word, din, din_valid, din_sync,
    input  bram_addr, bram_data, bram_we, status
  );

  modport slave (
    input  ctrl_word, din, din_valid, din_sync,
    output bram_addr, bram_data, bram_we, status
  );
endinterface

// File: rtl/iq_avg_snapshot_ctrl.sv
// ---------------------------------------------------------------------------
// iq_avg_snapshot_ctrl
//   Snapshot controller for the averaged I/Q stream. Watches the ss_ctrl
//   control word for a rising edge of arm, optionally waits for a frame-start
//   sync, then writes len_eff consecutive valid samples into a single-port
//   capture BRAM starting at address 0. Progress is reported through a
//   status word for a simulink2ppc register.
//
//   Ports:
//     user_clk    fabric clock, all logic on the rising edge
//     user_rst_n  asynchronous active-low reset
//     ss          iq_avg_snapshot_ctrl_if.slave (control, samples, BRAM, status)
//     ts_out_o    [31:0] cycle count at the first write of the last capture
//                 (only when IQ_SS_TIMESTAMP_EN is defined)
//
//   Optional feature macro: IQ_SS_TIMESTAMP_EN
//     Adds a free-running 32-bit cycle counter and the ts_out_o port.
// ---------------------------------------------------------------------------
module iq_avg_snapshot_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
) (
  input  logic                    user_clk,
  input  logic                    user_rst_n,
  iq_avg_snapshot_ctrl_if.slave   ss
`ifdef IQ_SS_TIMESTAMP_EN
  ,
  output logic [31:0]             ts_out_o
`endif
);

  localparam int          CNT_W   = ADDR_W + 1;
  localparam logic [31:0] DEPTH_U = 32'(1) << ADDR_W;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_SYNC = 2'd1;
  localparam logic [1:0] ST_CAPTURE   = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              arm_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              arm_rise;
  logic              abort;
  logic              sync_mode;
  logic [15:0]       len_field;
  logic [CNT_W-1:0]  len_eff;
  logic              accept;
  logic              unused_ctrl_bits;

  assign arm_rise         = ss.ctrl_word[0] & ~arm_q;
  assign sync_mode        = ss.ctrl_word[1];
  assign abort            = ss.ctrl_word[2];
  assign len_field        = ss.ctrl_word[31:16];
  assign unused_ctrl_bits = ^ss.ctrl_word[15:3];

  // A zero or oversized length means "fill the whole BRAM".
  always_comb begin
    len_eff = CNT_W'(len_field);
    if (len_field == 16'd0 || {16'd0, len_field} > DEPTH_U) begin
      len_eff = CNT_W'(DEPTH_U);
    end
  end

  // Next-state logic. Abort wins over everything, including a write that
  // would otherwise be accepted this cycle. The sync sample itself is the
  // first one captured, so WAIT_SYNC and CAPTURE share the write path.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    last_d  = last_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    accept  = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm_rise) begin
            state_d = sync_mode ? ST_WAIT_SYNC : ST_CAPTURE;
            count_d = '0;
            last_d  = len_eff - CNT_W'(1);
          end
        end
        ST_WAIT_SYNC: accept = ss.din_sync & ss.din_valid;
        ST_CAPTURE:   accept = ss.din_valid;
        default:      state_d = ST_IDLE;
      endcase
    end

    if (accept) begin
      we_d    = 1'b1;
      addr_d  = count_q[ADDR_W-1:0];
      data_d  = ss.din;
      count_d = count_q + CNT_W'(1);
      state_d = (count_q == last_q) ? ST_DONE : ST_CAPTURE;
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q <= ST_IDLE;
      arm_q   <= 1'b0;
      count_q <= '0;
      last_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      arm_q   <= ss.ctrl_word[0];
      count_q <= count_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign ss.bram_we   = we_q;
  assign ss.bram_addr = addr_q;
  assign ss.bram_data = data_q;
  assign ss.status    = {state_q == ST_DONE, state_q == ST_CAPTURE,
                         state_q == ST_WAIT_SYNC, 13'd0, 16'(count_q)};

`ifdef IQ_SS_TIMESTAMP_EN
  logic [31:0] cycle_q;
  logic [31:0] ts_q;

  // The stamp is loaded at the edge that raises bram_we for the first write,
  // so it is loaded with cycle_q+1: the counter value seen during that
  // write cycle.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      cycle_q <= '0;
      ts_q    <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (accept && count_q == '0) begin
        ts_q <= cycle_q + 32'd1;
      end
    end
  end

  assign ts_out_o = ts_q;
`endif

endmodule

// File: tb/tb_iq_avg_snapshot_ctrl.sv
// ---------------------------------------------------------------------------
// tb_iq_avg_snapshot_ctrl
//   Randomized bench for iq_avg_snapshot_ctrl. A behavioural model tracks
//   what the capture should have done (remaining samples, samples written)
//   and predicts the BRAM write port and status word each cycle.
// ---------------------------------------------------------------------------
module tb_iq_avg_snapshot_ctrl;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum {M_IDLE, M_WAIT, M_CAP, M_DONE} modelPhase_e;

  logic clk = 1'b0;
  logic rstN;

  logic              armReg, syncReg, abortReg;
  logic [15:0]       lenReg;
  logic [DATA_W-1:0] dinReg;
  logic              dinValid, dinSync;

  int checks   = 0;
  int failures = 0;

  modelPhase_e       phase;
  int                remaining;
  int                mCount;
  bit                mArmPrev;
  bit                expWe;
  int                expAddr;
  logic [DATA_W-1:0] expData;

  iq_avg_snapshot_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ssIf ();

  assign ssIf.ctrl_word = {lenReg, 13'd0, abortReg, syncReg, armReg};
  assign ssIf.din       = dinReg;
  assign ssIf.din_valid = dinValid;
  assign ssIf.din_sync  = dinSync;

`ifdef IQ_SS_TIMESTAMP_EN
  logic [31:0] tsOut;
  int unsigned mCycle;
  int unsigned expTs;
`endif

  iq_avg_snapshot_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .user_clk   (clk),
    .user_rst_n (rstN),
    .ss         (ssIf)
`ifdef IQ_SS_TIMESTAMP_EN
    ,
    .ts_out_o   (tsOut)
`endif
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model, advanced once per rising edge with the inputs that
  // were stable across it.
  task automatic modelStep();
    bit rise;
    int lenEff;
    rise     = armReg && !mArmPrev;
    mArmPrev = armReg;
    expWe    = 1'b0;
    if (abortReg) begin
      phase = M_IDLE;
    end else if ((phase == M_IDLE || phase == M_DONE) && rise) begin
      lenEff = int'(lenReg);
      if (lenEff == 0 || lenEff > DEPTH) lenEff = DEPTH;
      remaining = lenEff;
      mCount    = 0;
      phase     = syncReg ? M_WAIT : M_CAP;
    end else if ((phase == M_WAIT && dinSync && dinValid) || (phase == M_CAP && dinValid)) begin
      expWe   = 1'b1;
      expAddr = mCount;
      expData = dinReg;
`ifdef IQ_SS_TIMESTAMP_EN
      if (mCount == 0) expTs = mCycle + 1;
`endif
      mCount++;
      remaining--;
      phase = (remaining == 0) ? M_DONE : M_CAP;
    end
`ifdef IQ_SS_TIMESTAMP_EN
    mCycle++;
`endif
  endtask

  task automatic modelReset();
    phase     = M_IDLE;
    remaining = 0;
    mCount    = 0;
    mArmPrev  = 1'b0;
    expWe     = 1'b0;
`ifdef IQ_SS_TIMESTAMP_EN
    mCycle = 0;
    expTs  = 0;
`endif
  endtask

  task automatic checkCycle();
    logic [31:0] expStatus;
    expStatus = {phase == M_DONE, phase == M_CAP, phase == M_WAIT, 13'd0, 16'(mCount)};
    checkOutput("bram_we", 64'(ssIf.bram_we), 64'(expWe));
    if (expWe) begin
      checkOutput("bram_addr", 64'(ssIf.bram_addr), 64'(expAddr));
      checkOutput("bram_data", 64'(ssIf.bram_data), 64'(expData));
    end
    checkOutput("status", 64'(ssIf.status), 64'(expStatus));
`ifdef IQ_SS_TIMESTAMP_EN
    checkOutput("ts_out", 64'(tsOut), 64'(expTs));
`endif
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkCycle();
  endtask

  task automatic checkResetValues(input string when);
    checkOutput({when, "_we"}, 64'(ssIf.bram_we), 64'd0);
    checkOutput({when, "_addr"}, 64'(ssIf.bram_addr), 64'd0);
    checkOutput({when, "_data"}, 64'(ssIf.bram_data), 64'd0);
    checkOutput({when, "_status"}, 64'(ssIf.status), 64'd0);
`ifdef IQ_SS_TIMESTAMP_EN
    checkOutput({when, "_ts"}, 64'(tsOut), 64'd0);
`endif
  endtask

  // Random per-cycle stimulus; percentages give the odds of each event.
  task automatic applyStimulus(input int validPct, input int syncPct,
                               input int abortPct, input int armPct);
    dinReg   = {$urandom, $urandom};
    dinValid = ($urandom_range(0, 99) < validPct);
    dinSync  = ($urandom_range(0, 99) < syncPct);
    abortReg = ($urandom_range(0, 99) < abortPct);
    if ($urandom_range(0, 99) < armPct) armReg = ~armReg;
  endtask

  task automatic runScenario(input int lenVal, input bit syncVal, input int cycles,
                             input int validPct, input int syncPct,
                             input int abortPct, input int armPct);
    abortReg = 1'b0;
    armReg   = 1'b0;
    dinValid = 1'b0;
    dinSync  = 1'b0;
    stepCycle();
    lenReg  = 16'(lenVal);
    syncReg = syncVal;
    armReg  = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      stepCycle();
      applyStimulus(validPct, syncPct, abortPct, armPct);
    end
  endtask

  // Asynchronous reset applied between clock edges, checked before the
  // next rising edge so only the async path can clear the outputs.
  task automatic asyncResetPulse();
    #2 rstN = 1'b0;
    #1 checkResetValues("async_rst");
    modelReset();
    @(negedge clk);
    checkResetValues("held_rst");
    rstN = 1'b1;
  endtask

  initial begin
    rstN     = 1'b0;
    armReg   = 1'b0;
    syncReg  = 1'b0;
    abortReg = 1'b0;
    lenReg   = '0;
    dinReg   = '0;
    dinValid = 1'b0;
    dinSync  = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rstN = 1'b1;

    // Plain capture, then sync-qualified capture.
    runScenario(4, 1'b0, 12, 100, 0, 0, 0);
    runScenario(3, 1'b1, 30, 100, 12, 0, 0);
    // Full-depth captures: len 0 and len beyond the BRAM depth.
    runScenario(0, 1'b0, 2600, 50, 0, 0, 0);
    runScenario(1500, 1'b1, 1200, 100, 5, 0, 0);
    // Abort mid-capture followed by re-arm, and arm re-pulses.
    runScenario(8, 1'b0, 60, 70, 0, 4, 0);
    runScenario(3, 1'b0, 80, 80, 0, 0, 15);
    runScenario(1, 1'b1, 40, 60, 20, 0, 10);
    for (int s = 0; s < 25; s++) begin
      runScenario($urandom_range(1, 20), 1'($urandom_range(0, 1)), 50,
                  $urandom_range(30, 100), 10, (s % 3 == 0) ? 3 : 0, 5);
    end

    // Reset in the middle of a long capture, then capture again.
    runScenario(50, 1'b0, 20, 100, 0, 0, 0);
    asyncResetPulse();
    runScenario(6, 1'b0, 15, 100, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
